// File: rtl/gpio_pad_mode_ctrl.sv
// gpio_pad_mode_ctrl
//
// Per-pad drive-mode and output-value controller feeding the GPIO pad
// wrappers. Each pad holds a 3-bit DM word and an OUT bit. A mode change that
// flips a pad between input and output class goes through a break-before-make
// turnaround: the pad sits in plain input mode (001) for TURN_CYCLES cycles
// before the new mode is applied.
//
// Parameters:
//   NUM_PADS    - number of pads (1..64)
//   TURN_CYCLES - cycles held in safe input mode during a turnaround (>=1)
//   AW          - pad address width
//
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   wr_valid    - write request; accepted when wr_valid && wr_ready
//   wr_ready    - high while idle
//   wr_addr     - target pad index
//   wr_dm_en    - update mode with wr_dm (illegal modes stored as 001)
//   wr_dm       - requested mode
//   wr_out_en   - update output value with wr_out
//   wr_out      - requested output value
//   wr_err      - one-cycle pulse after an accepted out-of-range write
//   busy        - turnaround in progress
//   pad_dm      - per-pad DM[2:0], pad i at [3i+2:3i]
//   pad_out     - per-pad OUT
//   pad_in      - per-pad IN from the pad wrappers
//   gpio_in     - pad inputs as seen by the core
//
// Build option:
//   GPIO_IN_SYNC_EN - when defined, gpio_in passes through a two-flop
//                     synchronizer per pad; otherwise it is pad_in directly.

module gpio_pad_mode_ctrl #(
    parameter int NUM_PADS    = 8,
    parameter int TURN_CYCLES = 4,
    parameter int AW          = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [AW-1:0]         wr_addr,
    input  logic                  wr_dm_en,
    input  logic [2:0]            wr_dm,
    input  logic                  wr_out_en,
    input  logic                  wr_out,
    output logic                  wr_err,
    output logic                  busy,
    output logic [3*NUM_PADS-1:0] pad_dm,
    output logic [NUM_PADS-1:0]   pad_out,
    input  logic [NUM_PADS-1:0]   pad_in,
    output logic [NUM_PADS-1:0]   gpio_in
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_TURN = 1'b1;

    localparam logic [2:0] DM_IN = 3'b001;
    localparam logic [2:0] DM_PU = 3'b010;
    localparam logic [2:0] DM_PD = 3'b011;
    localparam logic [2:0] DM_OE = 3'b110;

    localparam int              CW        = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LOAD  = CW'(TURN_CYCLES - 1);
    localparam logic [AW:0]     PAD_LIMIT = (AW+1)'(NUM_PADS);

    logic [0:0]            r_state;
    logic [CW-1:0]         r_cnt;
    logic [AW-1:0]         r_tgt;
    logic [2:0]            r_new_dm;
    logic                  r_err;
    logic [3*NUM_PADS-1:0] r_dm;
    logic [NUM_PADS-1:0]   r_out;

    logic                  w_accept;
    logic                  w_addr_ok;
    logic [2:0]            w_legal_dm;
    logic [2:0]            w_cur_dm;
    logic                  w_turn;

    assign wr_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_TURN);
    assign wr_err    = r_err;
    assign pad_dm    = r_dm;
    assign pad_out   = r_out;

    assign w_accept  = wr_valid && wr_ready;
    assign w_addr_ok = ({1'b0, wr_addr} < PAD_LIMIT);

    always_comb begin
        case (wr_dm)
            DM_IN, DM_PU, DM_PD, DM_OE: w_legal_dm = wr_dm;
            default:                    w_legal_dm = DM_IN;
        endcase
    end

    // Current mode of the addressed pad (don't-care when out of range).
    always_comb begin
        w_cur_dm = DM_IN;
        for (int unsigned i = 0; i < NUM_PADS; i++) begin
            if (wr_addr == AW'(i)) begin
                w_cur_dm = r_dm[3*i +: 3];
            end
        end
    end

    // Turnaround only when the output-enable class actually changes.
    assign w_turn = wr_dm_en && ((w_legal_dm == DM_OE) != (w_cur_dm == DM_OE));

    // The safe mode is written into the pad register at acceptance, so the
    // pad naturally reads 001 for the whole TURN phase; the latched mode is
    // committed when the counter expires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_tgt    <= '0;
            r_new_dm <= DM_IN;
            r_err    <= 1'b0;
            r_dm     <= {NUM_PADS{DM_IN}};
            r_out    <= '0;
        end else begin
            r_err <= w_accept && !w_addr_ok;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_addr_ok) begin
                        for (int unsigned i = 0; i < NUM_PADS; i++) begin
                            if (wr_addr == AW'(i)) begin
                                if (wr_out_en) begin
                                    r_out[i] <= wr_out;
                                end
                                if (w_turn) begin
                                    r_dm[3*i +: 3] <= DM_IN;
                                end else if (wr_dm_en) begin
                                    r_dm[3*i +: 3] <= w_legal_dm;
                                end
                            end
                        end
                        if (w_turn) begin
                            r_new_dm <= w_legal_dm;
                            r_tgt    <= wr_addr;
                            r_cnt    <= CNT_LOAD;
                            r_state  <= ST_TURN;
                        end
                    end
                end
                ST_TURN: begin
                    if (r_cnt == '0) begin
                        for (int unsigned i = 0; i < NUM_PADS; i++) begin
                            if (r_tgt == AW'(i)) begin
                                r_dm[3*i +: 3] <= r_new_dm;
                            end
                        end
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef GPIO_IN_SYNC_EN
    logic [NUM_PADS-1:0] r_sync1;
    logic [NUM_PADS-1:0] r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pad_in;
            r_sync2 <= r_sync1;
        end
    end

    assign gpio_in = r_sync2;
`else
    assign gpio_in = pad_in;
`endif

endmodule

// File: tb/tb_gpio_pad_mode_ctrl.sv
// Directed bench for gpio_pad_mode_ctrl: main instance with 8 pads,
// TURN_CYCLES=4 and a widened address (so out-of-range indices are
// reachable), plus a small 2-pad instance with TURN_CYCLES=1.

module tb_gpio_pad_mode_ctrl;

    localparam int NP  = 8;
    localparam int TC  = 4;
    localparam int AWD = 4;

    logic            clk = 1'b0;
    logic            rst;

    logic            wr_valid, wr_ready, wr_dm_en, wr_out_en, wr_out, wr_err, busy;
    logic [AWD-1:0]  wr_addr;
    logic [2:0]      wr_dm;
    logic [3*NP-1:0] pad_dm;
    logic [NP-1:0]   pad_out, pad_in, gpio_in;

    logic            v1, rdy1, dm_en1, out_en1, out1, err1, busy1;
    logic [0:0]      a1;
    logic [2:0]      dm1;
    logic [5:0]      pad_dm1;
    logic [1:0]      pad_out1, pad_in1, gpio_in1;

    logic [3*NP-1:0] e_dm;
    logic [NP-1:0]   e_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gpio_pad_mode_ctrl #(.NUM_PADS(NP), .TURN_CYCLES(TC), .AW(AWD)) u_dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_dm_en(wr_dm_en), .wr_dm(wr_dm), .wr_out_en(wr_out_en), .wr_out(wr_out),
        .wr_err(wr_err), .busy(busy), .pad_dm(pad_dm), .pad_out(pad_out),
        .pad_in(pad_in), .gpio_in(gpio_in)
    );

    gpio_pad_mode_ctrl #(.NUM_PADS(2), .TURN_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .wr_valid(v1), .wr_ready(rdy1), .wr_addr(a1),
        .wr_dm_en(dm_en1), .wr_dm(dm1), .wr_out_en(out_en1), .wr_out(out1),
        .wr_err(err1), .busy(busy1), .pad_dm(pad_dm1), .pad_out(pad_out1),
        .pad_in(pad_in1), .gpio_in(gpio_in1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AWD-1:0] a, input logic de, input logic [2:0] d,
                      input logic oe, input logic o);
        wr_valid  = 1'b1;
        wr_addr   = a;
        wr_dm_en  = de;
        wr_dm     = d;
        wr_out_en = oe;
        wr_out    = o;
        tick();
        wr_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        wr_valid = 1'b0; wr_addr = '0; wr_dm_en = 1'b0; wr_dm = '0;
        wr_out_en = 1'b0; wr_out = 1'b0;
        pad_in = 8'hA5;
        v1 = 1'b0; a1 = '0; dm_en1 = 1'b0; dm1 = '0; out_en1 = 1'b0; out1 = 1'b0;
        pad_in1 = '0;
        e_dm  = 24'h249249;
        e_out = 8'h00;

        // Reset values
        repeat (3) tick();
        chk("rst_dm", pad_dm, e_dm);
        chk("rst_out", pad_out, e_out);
        chk("rst_ready", wr_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", wr_err, 1'b0);
        chk("rst_dm1", pad_dm1, 6'b001001);
`ifdef GPIO_IN_SYNC_EN
        chk("rst_gpio_in", gpio_in, 8'h00);
`else
        chk("rst_gpio_in", gpio_in, 8'hA5);
`endif
        rst = 1'b0;
        pad_in = 8'h00;
        tick();
        chk("post_rst_dm", pad_dm, e_dm);

        // TURN_CYCLES=1: safe mode after T, new mode after T+1
        v1 = 1'b1; a1 = 1'b0; dm_en1 = 1'b1; dm1 = 3'b110;
        tick();
        v1 = 1'b0;
        chk("tc1_safe_dm", pad_dm1, 6'b001001);
        chk("tc1_busy", busy1, 1'b1);
        tick();
        chk("tc1_new_dm", pad_dm1, 6'b001110);
        chk("tc1_idle", busy1, 1'b0);

        // Direct write pad2 -> 010
        wr(4'd2, 1'b1, 3'b010, 1'b0, 1'b0);
        e_dm[8:6] = 3'b010;
        chk("direct_dm", pad_dm, e_dm);
        chk("direct_busy", busy, 1'b0);
        chk("direct_ready", wr_ready, 1'b1);

        // Turnaround pad0 -> 110 with out=1
        wr(4'd0, 1'b1, 3'b110, 1'b1, 1'b1);
        e_out[0] = 1'b1;
        chk("ta_safe_dm", pad_dm, e_dm);
        chk("ta_out_now", pad_out, e_out);
        chk("ta_busy", busy, 1'b1);
        chk("ta_ready_low", wr_ready, 1'b0);
        for (int k = 1; k < TC; k++) begin
            tick();
            chk("ta_hold_dm", pad_dm, e_dm);
            chk("ta_hold_ready", wr_ready, 1'b0);
        end
        tick();
        e_dm[2:0] = 3'b110;
        chk("ta_new_dm", pad_dm, e_dm);
        chk("ta_done_busy", busy, 1'b0);
        chk("ta_done_ready", wr_ready, 1'b1);

        // Stall: pad1 -> 110 turnaround, then a pad4 write held while busy
        wr(4'd1, 1'b1, 3'b110, 1'b0, 1'b0);
        wr_valid = 1'b1; wr_addr = 4'd4; wr_dm_en = 1'b1; wr_dm = 3'b011;
        wr_out_en = 1'b0; wr_out = 1'b0;
        chk("stall_busy", busy, 1'b1);
        for (int k = 1; k < TC; k++) begin
            tick();
            chk("stall_hold_dm", pad_dm, e_dm);
        end
        tick();
        e_dm[5:3] = 3'b110;
        chk("stall_pad1_new", pad_dm, e_dm);
        tick();
        wr_valid = 1'b0;
        e_dm[14:12] = 3'b011;
        chk("stall_accept", pad_dm, e_dm);
        chk("stall_busy_end", busy, 1'b0);

        // Legalization
        wr(4'd3, 1'b1, 3'b011, 1'b0, 1'b0);
        e_dm[11:9] = 3'b011;
        chk("pad3_pd", pad_dm, e_dm);
        wr(4'd3, 1'b1, 3'b111, 1'b0, 1'b0);
        e_dm[11:9] = 3'b001;
        chk("legal_111", pad_dm, e_dm);
        wr(4'd2, 1'b1, 3'b100, 1'b0, 1'b0);
        e_dm[8:6] = 3'b001;
        chk("legal_100", pad_dm, e_dm);

        // Output-only, no-enable, and output clear
        wr(4'd7, 1'b0, 3'b110, 1'b1, 1'b1);
        e_out[7] = 1'b1;
        chk("out_only_out", pad_out, e_out);
        chk("out_only_dm", pad_dm, e_dm);
        chk("out_only_busy", busy, 1'b0);
        wr(4'd0, 1'b0, 3'b010, 1'b0, 1'b0);
        chk("noen_dm", pad_dm, e_dm);
        chk("noen_out", pad_out, e_out);
        wr(4'd0, 1'b0, 3'b000, 1'b1, 1'b0);
        e_out[0] = 1'b0;
        chk("out_clear", pad_out, e_out);

        // Out-of-range address
        wr(4'd9, 1'b1, 3'b110, 1'b1, 1'b1);
        chk("oor_err", wr_err, 1'b1);
        chk("oor_dm", pad_dm, e_dm);
        chk("oor_out", pad_out, e_out);
        chk("oor_busy", busy, 1'b0);
        tick();
        chk("oor_err_pulse", wr_err, 1'b0);

        // Illegal mode on an output pad legalizes to 001 -> turnaround
        wr(4'd0, 1'b1, 3'b101, 1'b0, 1'b0);
        e_dm[2:0] = 3'b001;
        chk("legal_ta_busy", busy, 1'b1);
        chk("legal_ta_dm", pad_dm, e_dm);
        repeat (TC) tick();
        chk("legal_ta_done", busy, 1'b0);
        chk("legal_ta_final", pad_dm, e_dm);

        // Reset during cycle 2 of a turnaround on pad1
        wr(4'd1, 1'b1, 3'b011, 1'b1, 1'b1);
        chk("mid_busy", busy, 1'b1);
        tick();
        #3 rst = 1'b1;
        #1;
        e_dm  = 24'h249249;
        e_out = 8'h00;
        chk("mid_rst_dm", pad_dm, e_dm);
        chk("mid_rst_out", pad_out, e_out);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", wr_ready, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("mid_discard_dm", pad_dm, e_dm);
        chk("mid_discard_busy", busy, 1'b0);

        // Full turnaround after reset
        wr(4'd1, 1'b1, 3'b110, 1'b0, 1'b0);
        chk("post_ta_safe", pad_dm, e_dm);
        for (int k = 1; k < TC; k++) begin
            tick();
            chk("post_ta_busy", busy, 1'b1);
        end
        tick();
        e_dm[5:3] = 3'b110;
        chk("post_ta_new", pad_dm, e_dm);
        chk("post_ta_idle", busy, 1'b0);

        // gpio_in path
        pad_in = 8'h20;
        #1;
`ifdef GPIO_IN_SYNC_EN
        chk("gin_rise0", gpio_in, 8'h00);
        tick();
        chk("gin_rise1", gpio_in, 8'h00);
        tick();
        chk("gin_rise2", gpio_in, 8'h20);
        pad_in = 8'h00;
        tick();
        chk("gin_fall1", gpio_in, 8'h20);
        tick();
        chk("gin_fall2", gpio_in, 8'h00);
`else
        chk("gin_rise", gpio_in, 8'h20);
        pad_in = 8'h00;
        #1;
        chk("gin_fall", gpio_in, 8'h00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpio_pad_mode_ctrl.md
# gpio_pad_mode_ctrl

Per-pad mode and data controller that sits directly upstream of the GPIO pad wrappers in the padframe. It holds each pad's 3-bit drive-mode word and output value, and drives them onto the pad wrappers' `DM[2:0]` and `OUT` pins. Any change that flips a pad between input and output passes through a timed break-before-make turnaround, so the pad never drives against an external driver. It also returns pad `IN` values to the core through an optional synchronizer.

## Interface
Parameters:
- `NUM_PADS`, 8 — number of pads controlled; range 1..64.
- `TURN_CYCLES`, 4 — cycles a pad is held in safe input mode during an input/output turnaround; must be ≥1.
- `AW`, ceil(log2(NUM_PADS)), minimum 1 — pad address width.

Ports:
- `clk`  in  1  — single clock; all state is updated on its rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `wr_valid`  in  1  — write request.
- `wr_ready`  out  1  — controller can accept a write.
- `wr_addr`  in  AW  — target pad index.
- `wr_dm_en`  in  1  — update the pad's mode with `wr_dm`.
- `wr_dm`  in  3  — requested mode.
- `wr_out_en`  in  1  — update the pad's output value with `wr_out`.
- `wr_out`  in  1  — requested output value.
- `wr_err`  out  1  — one-cycle pulse: an accepted write targeted an out-of-range pad.
- `busy`  out  1  — a turnaround is in progress.
- `pad_dm`  out  3*NUM_PADS  — per-pad `DM[2:0]`; pad i uses bits [3i+2:3i].
- `pad_out`  out  NUM_PADS  — per-pad `OUT`.
- `pad_in`  in  NUM_PADS  — per-pad `IN` from the pad wrappers.
- `gpio_in`  out  NUM_PADS  — pad input values as seen by the core.

## Operation
**Write acceptance**
- A write is accepted on a rising edge where `wr_valid && wr_ready`.
- `wr_ready` is high only in IDLE.

**Mode legalization**
- Legal modes: 001 (input, no pull), 010 (input, pull-up), 011 (input, pull-down), 110 (output enable).
- Any other `wr_dm` value is stored as 001.

**Output-enable class and turnaround**
- A mode's oe class is 1 for mode 110 and 0 otherwise.
- If `wr_dm_en` is set and the legalized mode's oe class differs from the pad's current oe class, a turnaround is required.
- Otherwise the write applies directly.

**FSM**
- IDLE: on an accepted write needing a turnaround:
  - drive the target pad's `pad_dm` to 001;
  - latch the new mode and the pad address;
  - load the counter with TURN_CYCLES−1;
  - go to TURN.
- IDLE, direct write: update the selected fields and stay in IDLE.
- TURN: decrement the counter each cycle. When the counter is 0 at an edge, write the latched mode into the pad's register and return to IDLE.
- `busy` = (state == TURN).

**Field updates and error handling**
- `wr_out` is applied at acceptance whenever `wr_out_en` is set, including writes that trigger a turnaround.
- Writes with neither enable set are accepted and change nothing.
- `wr_addr` ≥ NUM_PADS: the write is accepted, no state changes, and `wr_err` pulses for 1 cycle.
- Pads other than the one being turned around are unaffected by that turnaround.

## Timing
**Reset values**
- `pad_dm` = 001 for every pad.
- `pad_out` = 0.
- `gpio_in` = 0.
- `wr_err` = 0, `busy` = 0.
- State = IDLE, so `wr_ready` = 1.

**Latency** (write accepted at edge T)
- Direct write: the new `pad_dm`/`pad_out` is visible after edge T.
- Turnaround write:
  - `pad_dm` = 001 after edge T;
  - the new mode is visible after edge T+TURN_CYCLES;
  - `wr_ready` is low from after edge T until edge T+TURN_CYCLES;
  - `pad_out` is updated after edge T.
- `wr_err` is high for the cycle following edge T.

**Boundary conditions**
- Reset asserted mid-turnaround: the turnaround aborts immediately and every output takes its reset value; the latched mode is discarded.
- A write held on `wr_valid` while `busy` stalls and is accepted at the edge on which the FSM is in IDLE (edge T+TURN_CYCLES or later). Write fields must remain stable while stalled.
- TURN_CYCLES = 1: the new mode appears one edge after the safe-mode edge.
- A turnaround requested on a pad already at 001 still holds it at 001 for TURN_CYCLES cycles.

## Configuration
- `GPIO_IN_SYNC_EN` defined:
  - `gpio_in` is `pad_in` through a two-flop synchronizer per pad;
  - latency is 2 edges;
  - the synchronizer flops reset to 0.
- `GPIO_IN_SYNC_EN` undefined:
  - `gpio_in` = `pad_in` combinationally, latency 0;
  - during reset `gpio_in` reflects `pad_in`.

## Test plan
- Reset with `rst` high for 3 cycles -> all `pad_dm` = 001, `pad_out` = 0, `wr_ready` = 1, `busy` = 0.
- Write pad 2 with `wr_dm` = 010 -> pad 2 `pad_dm` = 010 one edge later; no `busy`.
- Write pad 0 with `wr_dm` = 110 and `wr_out` = 1, TURN_CYCLES = 4 -> `pad_dm[2:0]` = 001 for 4 cycles, then 110; `pad_out[0]` = 1 immediately; `wr_ready` low for 4 cycles.
- Write `wr_dm` = 111 to pad 3 -> stored as 001. Write `wr_addr` = 9 with NUM_PADS = 8 -> `wr_err` pulses 1 cycle and no output changes.
- Assert `rst` during cycle 2 of a turnaround on pad 1 -> `pad_dm` = 001 and `busy` = 0 at once; a 110 write after reset performs a full turnaround.
- With `GPIO_IN_SYNC_EN`, toggle `pad_in[5]` -> `gpio_in[5]` follows after 2 edges. Without the macro -> `gpio_in[5]` follows in the same cycle.
